stream_packetizer: RTL and testbench

STREAM_PACKETIZER -- requirements
Module: stream_packetizer

---
 rtl/pkt_pkg.sv | 22 ++
 rtl/stream_packetizer_if.sv | 14 +
 rtl/pkt_fifo.sv | 44 ++++
 rtl/stream_packetizer.sv | 147 ++++++++++++++
 tb/tb_stream_packetizer.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_pkg.sv
// Shared types and widths for the stream packetizer: FSM encoding, beat widths
// and the zero-extension used for header, payload and checksum beats.
package pkt_pkg;

    localparam int HDR_W   = 16;
    localparam int PAY_W   = 16;
    localparam int TDATA_W = 32;
    localparam int KEEP_W  = TDATA_W / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HEADER   = 3'd1,
        PAYLOAD  = 3'd2,
        CHECKSUM = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic logic [TDATA_W-1:0] zext(input logic [PAY_W-1:0] w);
        return {{(TDATA_W-PAY_W){1'b0}}, w};
    endfunction

endpackage

// File: rtl/stream_packetizer_if.sv
// AXI-Stream channel from the packetizer toward the DMA.
interface stream_packetizer_if;
    import pkt_pkg::*;

    logic               tvalid;
    logic [TDATA_W-1:0] tdata;
    logic [KEEP_W-1:0]  tkeep;
    logic               tlast;
    logic               tready;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);

endinterface

// File: rtl/pkt_fifo.sv
// Payload FIFO, power-of-two depth, wrap-bit pointers for full/empty; head word
// is presented combinationally so the packetizer can load it into its output register.
module pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/stream_packetizer.sv
// Frames compute-side words as header + payload (+ optional checksum) AXI-Stream packets.
// Define PKT_CHECKSUM_EN to append a 32-bit wrapping-sum beat carrying TLAST.
module stream_packetizer
    import pkt_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                M_AXIS_ACLK,
    input  logic                M_AXIS_ARESETN,
    input  logic                start,
    input  logic [HDR_W-1:0]    pkt_len,
    output logic                start_ready,
    input  logic [PAY_W-1:0]    din,
    input  logic                din_valid,
    output logic                din_ready,
    stream_packetizer_if.master m_axis,
    output logic                busy,
    output logic                done
);

    state_t             state;
    logic [HDR_W-1:0]   in_rem, out_rem, rem_after;
    logic [TDATA_W-1:0] tdata_q, tail_data;
    logic               tvalid_q, tlast_q, done_q;
    logic               push, pop, full, empty, tx, pay_tx;
    logic [PAY_W-1:0]   fifo_dout;

    pkt_fifo #(.DEPTH(DEPTH), .W(PAY_W)) u_fifo (
        .clk   (M_AXIS_ACLK),
        .rst_n (M_AXIS_ARESETN),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign start_ready    = (state == IDLE);
    assign busy           = !start_ready;
    assign done           = done_q;
    assign din_ready      = ((state == HEADER) || (state == PAYLOAD)) && !full && (in_rem != '0);
    assign push           = din_valid && din_ready;
    assign tx             = tvalid_q && m_axis.tready;
    assign pay_tx         = (state == PAYLOAD) && tx;
    assign rem_after      = out_rem - HDR_W'(pay_tx);
    assign m_axis.tvalid  = tvalid_q;
    assign m_axis.tdata   = tdata_q;
    assign m_axis.tkeep   = {KEEP_W{tvalid_q}};
    assign m_axis.tlast   = tlast_q;

`ifdef PKT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
    logic [TDATA_W-1:0] sum_q;

    // Summed at intake: the last word is always pushed before it can be transmitted.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN)                 sum_q <= '0;
        else if (start_ready && start)       sum_q <= '0;
        else if (push)                       sum_q <= sum_q + zext(din);
    end

    assign tail_data = sum_q;
`else
    localparam bit CHK_EN = 1'b0;
    assign tail_data = '0;
`endif

    // The output register reloads from the FIFO whenever it is empty or being drained.
    // NOTE: pop gets a default first so no path through the case leaves it unassigned.
    always_comb begin
        pop = 1'b0;
        case (state)
            HEADER:  pop = tx && (out_rem != '0) && !empty;
            PAYLOAD: pop = (!tvalid_q || m_axis.tready) && (rem_after != '0) && !empty;
            default: pop = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state    <= IDLE;
            in_rem   <= '0;
            out_rem  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) in_rem <= in_rem - 1'b1;

            case (state)
                IDLE: if (start) begin
                    state    <= HEADER;
                    in_rem   <= pkt_len;
                    out_rem  <= pkt_len;
                    tvalid_q <= 1'b1;
                    tdata_q  <= zext(pkt_len);
                    tlast_q  <= (pkt_len == '0) && !CHK_EN;
                end

                HEADER: if (tx) begin
                    if (out_rem == '0) begin
                        state    <= CHK_EN ? CHECKSUM : DONE;
                        tvalid_q <= CHK_EN;
                        tdata_q  <= tail_data;
                        tlast_q  <= CHK_EN;
                        done_q   <= !CHK_EN;
                    end else begin
                        state    <= PAYLOAD;
                        tvalid_q <= pop;
                        tdata_q  <= zext(fifo_dout);
                        tlast_q  <= (out_rem == 16'd1) && !CHK_EN;
                    end
                end

                PAYLOAD: begin
                    if (pay_tx) out_rem <= rem_after;
                    if (pay_tx && (rem_after == '0)) begin
                        state    <= CHK_EN ? CHECKSUM : DONE;
                        tvalid_q <= CHK_EN;
                        tdata_q  <= tail_data;
                        tlast_q  <= CHK_EN;
                        done_q   <= !CHK_EN;
                    end else if (!tvalid_q || m_axis.tready) begin
                        tvalid_q <= pop;
                        tdata_q  <= zext(fifo_dout);
                        tlast_q  <= (rem_after == 16'd1) && !CHK_EN;
                    end
                end

                CHECKSUM: if (tx) begin
                    state    <= DONE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    done_q   <= 1'b1;
                end

                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer: frames are predicted from packet length and
// payload, and a monitor compares every transmitted beat independently of the stimulus.
module tb_stream_packetizer;
    import pkt_pkg::*;

    localparam int DEPTH = 4;
`ifdef PKT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, start_ready, din_valid, din_ready, busy, done;
    logic [15:0] pkt_len, din;

    stream_packetizer_if axis ();

    stream_packetizer #(.DEPTH(DEPTH)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .start          (start),
        .pkt_len        (pkt_len),
        .start_ready    (start_ready),
        .din            (din),
        .din_valid      (din_valid),
        .din_ready      (din_ready),
        .m_axis         (axis),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    logic [15:0] din_q[$];
    int n_tests = 0, n_fail = 0;
    int beats_seen = 0, done_cnt = 0, exp_done = 0, din_acc = 0;
    int tready_mode = 0;
    bit rnd_din = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference frame: header = length, one beat per word, optional sum, TLAST on the final beat.
    task automatic expect_frame(input int len, input logic [15:0] w[$]);
        beat_t       b;
        logic [31:0] sum = 0;
        b.data = len;
        b.last = (len == 0) && !CHK;
        exp_q.push_back(b);
        for (int i = 0; i < len; i++) begin
            sum    = sum + w[i];
            b.data = w[i];
            b.last = (i == len - 1) && !CHK;
            exp_q.push_back(b);
        end
        if (CHK) begin
            b.data = sum;
            b.last = 1'b1;
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_words(input int len, output logic [15:0] w[$]);
        w.delete();
        for (int i = 0; i < len; i++) w.push_back(16'($urandom));
    endtask

    task automatic start_packet(input int len, input logic [15:0] w[$]);
        int guard = 0;
        @(negedge clk);
        while (!start_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("start_ready_wait", start_ready, 1);
        expect_frame(len, w);
        foreach (w[i]) din_q.push_back(w[i]);
        exp_done++;
        @(posedge clk); #1;
        start   = 1'b1;
        pkt_len = 16'(len);
        @(posedge clk); #1;
        start   = 1'b0;
        pkt_len = 16'($urandom);
        @(negedge clk);
        check("hdr_latency_valid", axis.tvalid, 1);
        check("hdr_latency_data", axis.tdata, len);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_cnt < exp_done && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", done_cnt, exp_done);
        check("frame_drained", exp_q.size(), 0);
    endtask

    task automatic wait_beats(input int target);
        int guard = 0;
        while (beats_seen < target && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("beats_reached", (beats_seen >= target), 1);
    endtask

    // TREADY: 0 = always high, 1 = random, 2 = held low
    initial begin
        axis.tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (tready_mode)
                0:       axis.tready = 1'b1;
                1:       axis.tready = 1'($urandom_range(0, 1));
                default: axis.tready = 1'b0;
            endcase
        end
    end

    // Payload source: offers the head of din_q, retires it on handshake
    initial begin
        din       = '0;
        din_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (din_q.size() > 0 && (!rnd_din || $urandom_range(0, 3) != 0)) begin
                din       = din_q[0];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            @(negedge clk);
            if (din_valid && din_ready && din_q.size() > 0) begin
                void'(din_q.pop_front());
                din_acc++;
            end
        end
    end

    // Monitor: compares each transfer against the scoreboard and checks hold-under-stall
    initial begin
        beat_t       b;
        bit          prev_stall = 1'b0, prev_done = 1'b0, prev_last = 1'b0;
        logic [31:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (axis.tvalid) begin
                    check("tkeep_valid", axis.tkeep, 4'hF);
                    if (prev_stall) begin
                        check("hold_data", axis.tdata, prev_data);
                        check("hold_last", axis.tlast, prev_last);
                    end
                    if (axis.tready) begin
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", axis.tdata);
                        end else begin
                            b = exp_q.pop_front();
                            check("tdata", axis.tdata, b.data);
                            check("tlast", axis.tlast, b.last);
                        end
                        beats_seen++;
                    end
                end else begin
                    check("tkeep_idle", axis.tkeep, 4'h0);
                    if (prev_stall) check("hold_valid", axis.tvalid, 1);
                end
                if (done) begin
                    check("done_width", prev_done, 0);
                    done_cnt++;
                end
                prev_stall = axis.tvalid && !axis.tready;
                prev_data  = axis.tdata;
                prev_last  = axis.tlast;
                prev_done  = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w[$];
        int base, acc0;
        start   = 1'b0;
        pkt_len = '0;

        repeat (3) @(negedge clk);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tdata", axis.tdata, 0);
        check("rst_tkeep", axis.tkeep, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_din_ready", din_ready, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_start_ready", start_ready, 1);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Basic three-word packet at full throughput
        tready_mode = 0;
        rnd_din     = 1'b0;
        w = '{16'h0011, 16'h0022, 16'h0033};
        start_packet(3, w);
        wait_done();

        // Empty packet
        w.delete();
        start_packet(0, w);
        wait_done();

        // Back-pressure: FIFO fills to DEPTH, header holds
        tready_mode = 2;
        rand_words(6, w);
        acc0 = din_acc;
        start_packet(6, w);
        repeat (10) @(negedge clk);
        check("bp_din_ready", din_ready, 0);
        check("bp_accepted", din_acc - acc0, DEPTH);
        check("bp_hdr_held", axis.tdata, 6);
        tready_mode = 0;
        wait_done();

        // Checksum carry case
        w = '{16'hFFFF, 16'h0001};
        start_packet(2, w);
        wait_done();

        // start pulsed mid-payload must be ignored
        base = beats_seen;
        rand_words(5, w);
        start_packet(5, w);
        wait_beats(base + 2);
        @(posedge clk); #1;
        start   = 1'b1;
        pkt_len = 16'd9;
        @(negedge clk);
        check("ignore_busy", start_ready, 0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        check("idle_after_ignore", start_ready, 1);

        // Reset after two payload beats, then a clean one-word packet
        base = beats_seen;
        rand_words(5, w);
        start_packet(5, w);
        wait_beats(base + 3);
        @(posedge clk); #2;
        rst_n = 1'b0;
        din_q.delete();
        exp_q.delete();
        exp_done--;
        #1;
        check("mid_rst_tvalid", axis.tvalid, 0);
        check("mid_rst_tdata", axis.tdata, 0);
        check("mid_rst_tkeep", axis.tkeep, 0);
        check("mid_rst_tlast", axis.tlast, 0);
        check("mid_rst_din_ready", din_ready, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_start_ready", start_ready, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        w = '{16'hABCD};
        start_packet(1, w);
        wait_done();

        // Randomised packets with random back-pressure and source gaps
        tready_mode = 1;
        rnd_din     = 1'b1;
        for (int p = 0; p < 15; p++) begin
            int len;
            len = $urandom_range(0, 9);
            rand_words(len, w);
            start_packet(len, w);
            wait_done();
        end

        repeat (4) @(negedge clk);
        check("done_total", done_cnt, exp_done);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
